seg_display_reader: RTL

SEG_DISPLAY_READER -- requirements
Module: seg_display_reader

---
 rtl/seg_display_reader_pkg.sv | 14 +
 rtl/seg_display_reader_if.sv | 18 +
 rtl/seg_display_reader_seg7_to_bcd.sv | 16 +
 rtl/seg_display_reader.sv | 97 +++++++++
 4 files changed

// File: rtl/seg_display_reader_pkg.sv
// seg_display_reader_pkg: segment patterns, blank code and FSM encodings shared by the
// washer display driver and the display reader.
package seg_display_reader_pkg;
  typedef logic [1:0] state_t;
  localparam state_t NOSIG = 2'd0;
  localparam state_t ACQ = 2'd1;
  localparam state_t LOCK = 2'd2;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  // index k holds the a..g pattern of digit k, a = MSB
  localparam logic [9:0][6:0] SEG_TAB = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };
endpackage

// File: rtl/seg_display_reader_if.sv
// seg_display_reader_if: segment bus in, decoded digits and status out.
interface seg_display_reader_if;
  logic [6:0] discode;
  logic [1:0] enable_shumaguan;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic valid;
  logic frame;
  logic seg_err;
  modport master (
    output discode, enable_shumaguan,
    input digit0, digit1, valid, frame, seg_err
  );
  modport slave (
    input discode, enable_shumaguan,
    output digit0, digit1, valid, frame, seg_err
  );
endinterface

// File: rtl/seg_display_reader_seg7_to_bcd.sv
// seg7_to_bcd: combinational 7-segment pattern to BCD decoder; all-off decodes to blank.
module seg7_to_bcd import seg_display_reader_pkg::*; (
  input logic [6:0] pat_i,
  output logic [3:0] val_o,
  output logic ok_o
);
  always_comb begin
    val_o = BLANK;
    ok_o = pat_i == SEG_BLANK;
    for (int k = 0; k < 10; k++)
      if (pat_i == SEG_TAB[k]) begin
        val_o = 4'(k);
        ok_o = 1'b1;
      end
  end
endmodule

// File: rtl/seg_display_reader.sv
// seg_display_reader: debounces a multiplexed two-digit 7-segment bus into BCD digits
// and tracks signal presence with a NOSIG/ACQ/LOCK state machine.
module seg_display_reader import seg_display_reader_pkg::*; #(
  parameter int STABLE_N = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  seg_display_reader_if.slave bus
);
  localparam logic [3:0] SN = 4'(STABLE_N);
  localparam logic [15:0] TO = 16'(TIMEOUT_CYC);
  logic [6:0] code_q;
  logic [1:0] en_q;
  logic in_vld_q;
  logic [3:0] dec_val;
  logic dec_ok;
  logic [1:0][3:0] cand_q, cand_d, cnt_q, cnt_d, dig_q, dig_d;
  logic [1:0] done_q, done_d, seen_q, seen_d, sel, acc;
  logic [15:0] tmo_q, tmo_d;
  state_t state_q, state_d;
  logic frame_q, err_q, err_d, fr, tmo_exp, to_nosig;
  seg7_to_bcd u_dec (
    .pat_i(code_q),
    .val_o(dec_val),
    .ok_o(dec_ok)
  );
  // in_vld_q keeps the all-zero reset copy of the enables from reading as illegal
  assign sel = {in_vld_q && en_q == 2'b01, in_vld_q && en_q == 2'b10};
  assign fr = &seen_q;
  always_comb begin
    cand_d = cand_q;
    cnt_d = cnt_q;
    done_d = done_q;
    dig_d = dig_q;
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      if (!sel[i]) begin
        cnt_d[i] = '0;
        done_d[i] = 1'b0;
      end else if (!dec_ok) begin
        cnt_d[i] = '0;
      end else begin
        cand_d[i] = dec_val;
        cnt_d[i] = dec_val != cand_q[i] ? 4'd1 : cnt_q[i] == SN ? SN : cnt_q[i] + 4'd1;
        acc[i] = cnt_d[i] == SN && !done_q[i];
      end
      if (acc[i]) begin
        done_d[i] = 1'b1;
        dig_d[i] = dec_val;
      end
    end
    tmo_exp = tmo_q == TO && !(|acc);
    tmo_d = |acc ? '0 : tmo_q == TO ? tmo_q : tmo_q + 16'd1;
    to_nosig = state_q != NOSIG && tmo_exp;
    state_d = state_q == NOSIG ? (|acc ? ACQ : NOSIG) :
              tmo_exp ? NOSIG :
              (state_q == ACQ && fr) ? LOCK : state_q;
    seen_d = to_nosig ? 2'b00 : fr ? acc : seen_q | acc;
    if (to_nosig) dig_d = {BLANK, BLANK};
    err_d = (in_vld_q && en_q == 2'b00) || (|sel && !dec_ok);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      en_q <= '0;
      in_vld_q <= 1'b0;
      cand_q <= '0;
      cnt_q <= '0;
      done_q <= '0;
      seen_q <= '0;
      dig_q <= {BLANK, BLANK};
      tmo_q <= '0;
      state_q <= NOSIG;
      frame_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      code_q <= bus.discode;
      en_q <= bus.enable_shumaguan;
      in_vld_q <= 1'b1;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      seen_q <= seen_d;
      dig_q <= dig_d;
      tmo_q <= tmo_d;
      state_q <= state_d;
      frame_q <= fr;
      err_q <= err_d;
    end
  end
  assign bus.digit0 = dig_q[0];
  assign bus.digit1 = dig_q[1];
  assign bus.valid = state_q == LOCK;
  assign bus.frame = frame_q;
  assign bus.seg_err = err_q;
endmodule
